// File: rtl/uart_pkg.sv
// Shared UART constants and types, used by uart_tx and uart_rx.
// Contents: default line-format parameters, derived packet geometry, and the
// receiver FSM state type.
package uart_pkg;

  // Default line format
  localparam int unsigned CLOCKS_PER_PULSE = 4;
  localparam int unsigned BITS_PER_WORD    = 8;
  localparam int unsigned PACKET_SIZE      = 13;
  localparam int unsigned W_OUT            = 16;

  // Derived geometry for the default format
  localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned END_BITS  = PACKET_SIZE - BITS_PER_WORD - 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: deserialises the uart_tx line format into W_OUT-bit words.
// Each bit is sampled at its midpoint; NUM_WORDS packets are assembled into
// one output word (first packet in the least significant bits).
// Ports:
//   clk       - system clock
//   rstn      - synchronous active-low reset
//   rx        - serial line, idle high
//   m_data    - received word
//   m_valid   - m_data valid (valid/ready master)
//   m_ready   - downstream accepts
//   frame_err - one-cycle pulse on a bad end bit
//   overflow  - one-cycle pulse when a completed word is dropped
// Optional macro UART_RX_SYNC_EN: passes rx through a 2-flop synchroniser
// (reset to 1) before the FSM, adding 2 cycles of latency.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE      = uart_pkg::PACKET_SIZE,
  parameter int unsigned W_OUT            = uart_pkg::W_OUT,
  parameter int unsigned INVERT_DATA      = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow
);
  import uart_pkg::*;

  localparam int unsigned NumWords = W_OUT / BITS_PER_WORD;
  localparam int unsigned EndBits  = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int unsigned MaxBits  = (BITS_PER_WORD > EndBits) ? BITS_PER_WORD : EndBits;
  localparam int unsigned CycW     = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BitW     = (MaxBits > 1) ? $clog2(MaxBits) : 1;
  localparam int unsigned WordW    = (NumWords > 1) ? $clog2(NumWords) : 1;

  localparam logic [CycW-1:0]  CycLast     = CycW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CycW-1:0]  CycHalf     = CycW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BitW-1:0]  BitLastData = BitW'(BITS_PER_WORD - 1);
  localparam logic [BitW-1:0]  BitLastEnd  = BitW'(EndBits - 1);
  localparam logic [WordW-1:0] WordLast    = WordW'(NumWords - 1);
  localparam logic [W_OUT-1:0] One         = {{(W_OUT - 1){1'b0}}, 1'b1};
  localparam logic             Inv         = (INVERT_DATA != 0);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], rx};
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  rx_state_t        state_q, state_d;
  logic [CycW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WordW-1:0] word_cnt_q, word_cnt_d;
  logic [W_OUT-1:0] shift_q, shift_d;
  logic [W_OUT-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  // Falling-edge detector is only live once the line has been seen high.
  logic             armed_q, armed_d;
  logic [W_OUT-1:0] bit_mask;
  logic             tick;

  assign tick     = (cyc_cnt_q == CycLast);
  assign bit_mask = One << (word_cnt_q * BITS_PER_WORD + bit_cnt_q);

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q & ~m_ready;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    armed_d     = armed_q;

    unique case (state_q)
      IDLE: begin
        cyc_cnt_d = '0;
        bit_cnt_d = '0;
        if (armed_q && !rx_s) begin
          state_d = START;
          armed_d = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end
      START: begin
        if (cyc_cnt_q == CycHalf) begin
          cyc_cnt_d = '0;
          if (rx_s) begin
            // Glitch: line already high again, so re-arm immediately.
            state_d = IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cyc_cnt_d = '0;
          shift_d   = (rx_s ^ Inv) ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
          if (bit_cnt_q == BitLastData) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          cyc_cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            word_cnt_d  = '0;
            bit_cnt_d   = '0;
            state_d     = IDLE;
          end else if (bit_cnt_q == BitLastEnd) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            // End bit was high; arming here keeps zero-gap packets intact
            // even when less than one idle cycle remains in the bit period.
            armed_d   = 1'b1;
            if (word_cnt_q == WordLast) begin
              word_cnt_d = '0;
              if (!m_valid_q || m_ready) begin
                m_data_d  = shift_q;
                m_valid_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      armed_q     <= armed_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
